// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the cache clients, the arbiter
// and the shared single-beat memory port.
interface mem_port_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_grant;
    logic        ic_data_valid;
    logic        ic_last;

    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_grant;
    logic        dc_data_valid;
    logic        dc_last;

    logic [31:0] rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_ack, mem_rdata,
        output ic_grant, ic_data_valid, ic_last,
        output dc_grant, dc_data_valid, dc_last,
        output rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_ack, mem_rdata,
        input  ic_grant, ic_data_valid, ic_last,
        input  dc_grant, dc_data_valid, dc_last,
        input  rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one beat-oriented memory port between i-cache line
// refills and d-cache refills/stores, round-robin on contention.
module mem_port_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [31:0] LINE_MASK = 32'(BURST_LEN * 4 - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state;
    logic          last_dc;
    logic [BW-1:0] beat;
    logic          pick_dc;
    logic          final_beat;

    // dc wins unless ic also asks and dc was served last
    assign pick_dc    = bus.dc_req & ~(bus.ic_req & last_dc);
    assign final_beat = bus.mem_we | (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_dc           <= 1'b0;
            beat              <= '0;
            bus.ic_grant      <= 1'b0;
            bus.ic_data_valid <= 1'b0;
            bus.ic_last       <= 1'b0;
            bus.dc_grant      <= 1'b0;
            bus.dc_data_valid <= 1'b0;
            bus.dc_last       <= 1'b0;
            bus.rdata         <= '0;
            bus.mem_req       <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
        end else begin
            bus.ic_grant      <= 1'b0;
            bus.ic_data_valid <= 1'b0;
            bus.ic_last       <= 1'b0;
            bus.dc_grant      <= 1'b0;
            bus.dc_data_valid <= 1'b0;
            bus.dc_last       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ic_req | bus.dc_req) begin
                        last_dc     <= pick_dc;
                        beat        <= '0;
                        bus.mem_req <= 1'b1;
                        if (pick_dc) begin
                            state         <= BUSY_D;
                            bus.dc_grant  <= 1'b1;
                            bus.mem_we    <= bus.dc_we;
                            bus.mem_wdata <= bus.dc_wdata;
                            bus.mem_addr  <= bus.dc_we
                                ? (bus.dc_addr & ~32'h3)
                                : (bus.dc_addr & ~LINE_MASK);
                        end else begin
                            state         <= BUSY_I;
                            bus.ic_grant  <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_wdata <= '0;
                            bus.mem_addr  <= bus.ic_addr & ~LINE_MASK;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_req & bus.mem_ack) begin
                        bus.rdata    <= bus.mem_rdata;
                        bus.mem_addr <= bus.mem_addr + 32'd4;
                        beat         <= beat + 1'b1;
                        if (state == BUSY_D) begin
                            bus.dc_data_valid <= 1'b1;
                            bus.dc_last       <= final_beat;
                        end else begin
                            bus.ic_data_valid <= 1'b1;
                            bus.ic_last       <= final_beat;
                        end
                        if (final_beat) begin
                            bus.mem_req <= 1'b0;
                            bus.mem_we  <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level model of the arbitration and burst rules.
module tb_mem_port_arbiter;
    localparam int BL = 4;
    localparam logic [31:0] LINE = 32'(4 * BL);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.BURST_LEN(BL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          m_busy, m_dc, m_store, m_last_dc;
    int          m_done, m_len;
    logic [31:0] m_addr, m_wdata, e_rdata;
    bit          e_ic_grant, e_dc_grant;
    bit          e_ic_dv, e_dc_dv, e_ic_last, e_dc_last;
    bit          rdata_chk;

    logic [31:0] beat_q[$];
    int          grant_q[$];

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: who owns the port, where
    // the next beat goes and how many beats remain.
    task automatic model_step();
        logic [31:0] a;
        e_ic_grant = 0; e_dc_grant = 0;
        e_ic_dv = 0; e_dc_dv = 0;
        e_ic_last = 0; e_dc_last = 0;
        rdata_chk = 0;
        if (!rst_n) begin
            m_busy = 0; m_last_dc = 0; m_store = 0;
            m_addr = 0; m_wdata = 0; e_rdata = 0;
            rdata_chk = 1;
        end else if (!m_busy) begin
            if (bus.ic_req || bus.dc_req) begin
                m_dc = bus.dc_req && !(bus.ic_req && m_last_dc);
                m_last_dc = m_dc;
                m_store = m_dc && bus.dc_we;
                m_len = m_store ? 1 : BL;
                a = m_dc ? bus.dc_addr : bus.ic_addr;
                m_addr = m_store ? a - (a % 4) : a - (a % LINE);
                m_wdata = bus.dc_wdata;
                m_done = 0;
                m_busy = 1;
                if (m_dc) e_dc_grant = 1;
                else e_ic_grant = 1;
            end
        end else if (bus.mem_ack) begin
            e_rdata = bus.mem_rdata;
            rdata_chk = 1;
            m_done++;
            m_addr = m_addr + 4;
            if (m_dc) e_dc_dv = 1;
            else e_ic_dv = 1;
            if (m_done == m_len) begin
                if (m_dc) e_dc_last = 1;
                else e_ic_last = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        check("ic_grant", 32'(bus.ic_grant), 32'(e_ic_grant));
        check("dc_grant", 32'(bus.dc_grant), 32'(e_dc_grant));
        check("ic_dv", 32'(bus.ic_data_valid), 32'(e_ic_dv));
        check("dc_dv", 32'(bus.dc_data_valid), 32'(e_dc_dv));
        check("ic_last", 32'(bus.ic_last), 32'(e_ic_last));
        check("dc_last", 32'(bus.dc_last), 32'(e_dc_last));
        check("mem_req", 32'(bus.mem_req), 32'(m_busy));
        check("mem_we", 32'(bus.mem_we), 32'(m_busy && m_store));
        check("mem_addr", bus.mem_addr, m_addr);
        if (m_busy && m_store)
            check("mem_wdata", bus.mem_wdata, m_wdata);
        if (rdata_chk)
            check("rdata", bus.rdata, e_rdata);
        if (bus.ic_grant) grant_q.push_back(0);
        if (bus.dc_grant) grant_q.push_back(1);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(int n, bit hold);
        repeat (n) begin
            bus.mem_rdata = $urandom;
            if (bus.mem_req && bus.mem_ack)
                beat_q.push_back(bus.mem_addr);
            tick();
            if (!hold) begin
                if (bus.ic_grant) bus.ic_req = 0;
                if (bus.dc_grant) bus.dc_req = 0;
            end
        end
    endtask

    initial begin
        rst_n = 0;
        bus.ic_req = 0; bus.ic_addr = 0;
        bus.dc_req = 0; bus.dc_we = 0;
        bus.dc_addr = 0; bus.dc_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        #2;
        run(2, 0);
        rst_n = 1;

        // aligned i-cache refill, ack every cycle
        bus.ic_req = 1; bus.ic_addr = 32'h0000_104C;
        bus.mem_ack = 1;
        beat_q.delete();
        run(8, 0);
        check("r035_beats", 32'(beat_q.size()), 32'd4);
        check("r035_a0", beat_q[0], 32'h0000_1040);
        check("r035_a3", beat_q[3], 32'h0000_104C);

        // contention straight after reset: dc first
        rst_n = 0;
        run(2, 0);
        rst_n = 1;
        bus.ic_req = 1; bus.ic_addr = 32'h0000_3000;
        bus.dc_req = 1; bus.dc_we = 0;
        bus.dc_addr = 32'h0000_4010;
        grant_q.delete();
        run(14, 0);
        check("r036_n", 32'(grant_q.size()), 32'd2);
        check("r036_g0", 32'(grant_q[0]), 32'd1);
        check("r036_g1", 32'(grant_q[1]), 32'd0);

        // single-beat store
        bus.dc_req = 1; bus.dc_we = 1;
        bus.dc_addr = 32'h0000_2003;
        bus.dc_wdata = 32'hDEAD_BEEF;
        beat_q.delete();
        run(5, 0);
        bus.dc_we = 0;
        check("r037_beats", 32'(beat_q.size()), 32'd1);
        check("r037_a0", beat_q[0], 32'h0000_2000);

        // mid-burst ack stall
        bus.ic_req = 1; bus.ic_addr = 32'h0000_5008;
        bus.mem_ack = 0;
        beat_q.delete();
        run(1, 0);
        bus.mem_ack = 1; run(2, 0);
        bus.mem_ack = 0; run(3, 0);
        bus.mem_ack = 1; run(4, 0);
        check("r038_beats", 32'(beat_q.size()), 32'd4);
        check("r038_a2", beat_q[2], 32'h0000_5008);

        // reset in the middle of a burst
        bus.ic_req = 1; bus.ic_addr = 32'h0000_6000;
        run(3, 0);
        rst_n = 0;
        run(1, 0);
        rst_n = 1;
        run(3, 0);
        bus.ic_req = 1; bus.ic_addr = 32'h0000_7000;
        run(8, 0);

        // refill at the top of the address space
        bus.ic_req = 1; bus.ic_addr = 32'hFFFF_FFF0;
        beat_q.delete();
        run(8, 0);
        check("r040_beats", 32'(beat_q.size()), 32'd4);
        check("r040_a0", beat_q[0], 32'hFFFF_FFF0);
        check("r040_a3", beat_q[3], 32'hFFFF_FFFC);

        // both held continuously: strict alternation
        bus.ic_req = 1; bus.dc_req = 1; bus.dc_we = 0;
        grant_q.delete();
        run(30, 1);
        check("alt_n_ge4", 32'(grant_q.size() >= 4), 32'd1);
        check("alt_g0", 32'(grant_q[0]), 32'd1);
        check("alt_g1", 32'(grant_q[1]), 32'd0);
        check("alt_g2", 32'(grant_q[2]), 32'd1);
        check("alt_g3", 32'(grant_q[3]), 32'd0);
        bus.ic_req = 0; bus.dc_req = 0;
        run(6, 0);

        // random traffic, drops, stalls and occasional resets
        repeat (3000) begin
            if (!bus.ic_req && $urandom_range(3) == 0) begin
                bus.ic_req = 1;
                bus.ic_addr = ($urandom_range(7) == 0)
                    ? 32'hFFFF_FFE0 | 32'($urandom_range(31))
                    : $urandom;
            end else if (bus.ic_req && $urandom_range(15) == 0)
                bus.ic_req = 0;
            if (!bus.dc_req && $urandom_range(3) == 0) begin
                bus.dc_req = 1;
                bus.dc_we = 1'($urandom_range(1));
                bus.dc_addr = $urandom;
                bus.dc_wdata = $urandom;
            end else if (bus.dc_req && $urandom_range(15) == 0)
                bus.dc_req = 0;
            bus.mem_ack = ($urandom_range(2) != 0);
            rst_n = ($urandom_range(199) != 0);
            run(1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: BURST_LEN, default 4 (power of two, 2..16), beats per cache-line refill.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ic_req  in  1  i-cache line-refill request; held until ic_grant.
REQ-005 ic_addr  in  32  i-cache miss byte address.
REQ-006 ic_grant  out  1  one-cycle pulse: i-cache request accepted.
REQ-007 ic_data_valid  out  1  one-cycle pulse per returned i-cache beat.
REQ-008 ic_last  out  1  with ic_data_valid: final beat of the burst.
REQ-009 dc_req  in  1  d-cache request (refill or store); held until dc_grant.
REQ-010 dc_we  in  1  1 = single-beat store, 0 = line refill.
REQ-011 dc_addr  in  32  d-cache byte address.
REQ-012 dc_wdata  in  32  store data.
REQ-013 dc_grant  out  1  one-cycle pulse: d-cache request accepted.
REQ-014 dc_data_valid  out  1  one-cycle pulse per d-cache beat (refill data or store completion).
REQ-015 dc_last  out  1  with dc_data_valid: final beat.
REQ-016 rdata  out  32  registered returned word, valid while either data_valid is high.
REQ-017 mem_req  out  1  memory beat request, registered.
REQ-018 mem_we  out  1  memory write, registered.
REQ-019 mem_addr  out  32  memory word address (byte address, bits[1:0]=0), registered.
REQ-020 mem_wdata  out  32  memory write data, registered.
REQ-021 mem_ack  in  1  beat accepted/completed; mem_rdata valid same cycle.
REQ-022 mem_rdata  in  32  memory read data.

Function
REQ-023 FSM states IDLE, BUSY_I, BUSY_D; single owner of memory port at a time.
REQ-024 IDLE, only one of ic_req/dc_req high -> grant it; both high -> grant the requester not served last; last_served resets to IC (dc wins first contention).
REQ-025 Grant edge: grant pulse high next cycle, state -> BUSY_x, mem_req<=1, beat counter<=0, address/we/wdata latched.
REQ-026 Refill: mem_addr = addr with low log2(BURST_LEN)+2 bits cleared (line-aligned), mem_we=0.
REQ-027 Store (dc_we=1): mem_addr = {dc_addr[31:2],2'b00}, mem_we=1, mem_wdata=dc_wdata, exactly one beat.
REQ-028 Each edge with mem_req & mem_ack: rdata<=mem_rdata, owner data_valid<=1 for one cycle, mem_addr+=4 (wraps mod 2^32), beat+=1.
REQ-029 Final beat (beat==BURST_LEN-1, or store): owner last<=1 alongside data_valid, mem_req<=0, mem_we<=0, state -> IDLE.
REQ-030 mem_ack ignored while mem_req=0; requests ignored in BUSY states; no back-to-back grant: at least one IDLE cycle between transactions.
REQ-031 Request dropped before grant -> no transaction, no pulse.
REQ-032 last_served updated at grant; fairness only under simultaneous requests.
REQ-033 Latency: req high in IDLE -> grant and mem_req 1 cycle later; data_valid 1 cycle after each mem_ack.

Reset
REQ-034 rst_n=0 at edge: state IDLE, last_served IC, beat 0, all outputs 0 (mem_addr, mem_wdata, rdata = 0); in-flight burst aborted, no further data_valid.

Verification
REQ-035 ic_req only, ic_addr=0x0000_104C, mem_ack every cycle -> ic_grant, mem_addr 0x1040,0x1044,0x1048,0x104C, 4 ic_data_valid, ic_last on 4th, mem_req low after.
REQ-036 ic_req & dc_req same cycle after reset -> dc granted first; after dc_last + 1 IDLE cycle, ic granted.
REQ-037 dc store dc_addr=0x2003, dc_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x2000, one beat, dc_data_valid & dc_last together.
REQ-038 mem_ack stalled 3 cycles mid-burst -> mem_addr held, no data_valid pulses until ack resumes; beat count correct.
REQ-039 rst_n low after 2nd beat -> next cycle mem_req=0, no further data_valid, IDLE; new ic_req then granted normally.
REQ-040 Refill at ic_addr=0xFFFF_FFF0 -> addresses 0xFFFFFFF0..0xFFFFFFFC, no corruption; both requests held continuously -> grants alternate dc, ic, dc, ic.
